// File: rtl/loba_pkg.sv
// Shared types and helpers for the leading-one-based approximate multiplier.
// The optional Al*Bl term is enabled by defining LOBA_LL_TERM_EN.
package loba_pkg;

    // Field widths of the packed split record; they bound W <= 16 and N <= 256.
    localparam int unsigned LOBA_SEG_W_MAX = 16;
    localparam int unsigned LOBA_K_W_MAX   = 8;

    function automatic int unsigned shift_bias(input int unsigned w);
        return 2 * (w - 1);
    endfunction

    function automatic int unsigned lo_idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic [LOBA_SEG_W_MAX-1:0] xh;
        logic [LOBA_K_W_MAX-1:0]   kh;
        logic [LOBA_SEG_W_MAX-1:0] xl;
        logic [LOBA_K_W_MAX-1:0]   kl;
    } loba_split_t;

endpackage

// File: rtl/loba_split_p.sv
// Combinational operand split into a high and a low W-bit leading-one segment
// together with the bit index of each segment's top bit.
module loba_split_p
    import loba_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0]           x,
    output logic [W-1:0]           xh,
    output logic [lo_idx_w(N)-1:0] kh,
    output logic [W-1:0]           xl,
    output logic [lo_idx_w(N)-1:0] kl
);

    localparam int unsigned   KW       = lo_idx_w(N);
    localparam logic [N-1:0]  SEG_MASK = N'({W{1'b1}});
    localparam logic [KW-1:0] K_MIN    = KW'(W - 1);

    function automatic logic [KW-1:0] lead_one(input logic [N-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < N; i++)
            if (v[i]) k = KW'(i);
        return k;
    endfunction

    logic [N-1:0]  rem;
    logic [KW-1:0] sh_h;

    always_comb begin
        kh   = K_MIN;
        xh   = x[W-1:0];
        sh_h = '0;
        rem  = '0;
        if ((x >> W) != '0) begin
            kh   = lead_one(x);
            sh_h = kh - K_MIN;
            xh   = W'(x >> sh_h);
            rem  = x & ~(SEG_MASK << sh_h);
        end
        // Small remainders are kept exactly at the minimum index.
        kl = K_MIN;
        xl = rem[W-1:0];
        if ((rem >> W) != '0) begin
            kl = lead_one(rem);
            xl = W'(rem >> (kl - K_MIN));
        end
    end

endmodule

// File: rtl/loba_pipe_mult.sv
// Three-stage approximate multiplier with valid/ready on both sides and a tag
// sideband. Define LOBA_LL_TERM_EN to add the Al*Bl partial product.
module loba_pipe_mult
    import loba_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned W     = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned   KW   = lo_idx_w(N);
    localparam int unsigned   PW   = 2 * N;
    localparam int unsigned   SW   = LOBA_K_W_MAX + 1;
    localparam logic [SW-1:0] BIAS = SW'(shift_bias(W));

    logic [W-1:0]  ah, al, bh, bl;
    logic [KW-1:0] kah, kal, kbh, kbl;

    loba_split_p #(.N(N), .W(W)) u_split_a (
        .x(a), .xh(ah), .kh(kah), .xl(al), .kl(kal)
    );

    loba_split_p #(.N(N), .W(W)) u_split_b (
        .x(b), .xh(bh), .kh(kbh), .xl(bl), .kl(kbl)
    );

    loba_split_t split_a, split_b;

    always_comb begin
        split_a    = '0;
        split_a.xh = LOBA_SEG_W_MAX'(ah);
        split_a.kh = LOBA_K_W_MAX'(kah);
        split_a.xl = LOBA_SEG_W_MAX'(al);
        split_a.kl = LOBA_K_W_MAX'(kal);
        split_b    = '0;
        split_b.xh = LOBA_SEG_W_MAX'(bh);
        split_b.kh = LOBA_K_W_MAX'(kbh);
        split_b.xl = LOBA_SEG_W_MAX'(bl);
        split_b.kl = LOBA_K_W_MAX'(kbl);
    end

    // Every index is >= W-1, so the biased shift never goes negative.
    function automatic logic [PW-1:0] term(
        input logic [LOBA_SEG_W_MAX-1:0] x,
        input logic [LOBA_K_W_MAX-1:0]   kx,
        input logic [LOBA_SEG_W_MAX-1:0] y,
        input logic [LOBA_K_W_MAX-1:0]   ky
    );
        logic [SW-1:0] sh;
        sh = SW'(kx) + SW'(ky) - BIAS;
        return (PW'(x) * PW'(y)) << sh;
    endfunction

    loba_split_t      s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic             s1_valid, s2_valid;
    logic [PW-1:0]    pp_hh, pp_hl, pp_lh, sum;
`ifdef LOBA_LL_TERM_EN
    logic [PW-1:0]    pp_ll;
`endif

    logic s3_load, s2_ready, s1_adv;

    assign s3_load  = !out_valid || out_ready;
    assign s2_ready = !s2_valid || s3_load;
    assign s1_adv   = s1_valid && s2_ready;
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= split_a;
                s1_b   <= split_b;
                s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            pp_hh    <= '0;
            pp_hl    <= '0;
            pp_lh    <= '0;
`ifdef LOBA_LL_TERM_EN
            pp_ll    <= '0;
`endif
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag <= s1_tag;
                pp_hh  <= term(s1_a.xh, s1_a.kh, s1_b.xh, s1_b.kh);
                pp_hl  <= term(s1_a.xh, s1_a.kh, s1_b.xl, s1_b.kl);
                pp_lh  <= term(s1_a.xl, s1_a.kl, s1_b.xh, s1_b.kh);
`ifdef LOBA_LL_TERM_EN
                pp_ll  <= term(s1_a.xl, s1_a.kl, s1_b.xl, s1_b.kl);
`endif
            end
        end
    end

    always_comb begin
`ifdef LOBA_LL_TERM_EN
        sum = pp_hh + pp_hl + pp_lh + pp_ll;
`else
        sum = pp_hh + pp_hl + pp_lh;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
            out_tag   <= '0;
        end else if (s3_load) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                p       <= sum;
                out_tag <= s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_loba_pipe_mult.sv
// Self-checking bench for loba_pipe_mult: arithmetic reference model with a
// scoreboard, plus directed latency, throughput, stall and reset scenarios.
module tb_loba_pipe_mult;

    localparam int unsigned N     = 16;
    localparam int unsigned W     = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a, b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   p;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    loba_pipe_mult #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .out_tag(out_tag)
    );

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;

    longint unsigned  exp_p[$];
    logic [TAG_W-1:0] exp_tag[$];

    bit               stall_prev = 1'b0;
    logic [2*N-1:0]   prev_p;
    logic [TAG_W-1:0] prev_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Top W-bit segment of x and the bit position of its most significant bit.
    function automatic void seg(input longint unsigned x, output longint unsigned h,
                                output int unsigned k);
        if (x < (64'd1 << W)) begin
            h = x;
            k = W - 1;
        end else begin
            k = 0;
            while ((x >> (k + 1)) != 0) k++;
            h = x >> (k - W + 1);
        end
    endfunction

    function automatic longint unsigned model_p(input longint unsigned x, input longint unsigned y);
        longint unsigned xh, xl, yh, yl, rx, ry;
        int unsigned     kxh, kxl, kyh, kyl, bias;
        seg(x, xh, kxh);
        rx = (x < (64'd1 << W)) ? 64'd0 : x - (xh << (kxh - W + 1));
        seg(rx, xl, kxl);
        seg(y, yh, kyh);
        ry = (y < (64'd1 << W)) ? 64'd0 : y - (yh << (kyh - W + 1));
        seg(ry, yl, kyl);
        bias = 2 * (W - 1);
        model_p = ((xh * yh) << (kxh + kyh - bias))
                + ((xh * yl) << (kxh + kyl - bias))
                + ((xl * yh) << (kxl + kyh - bias));
`ifdef LOBA_LL_TERM_EN
        model_p += ((xl * yl) << (kxl + kyl - bias));
`endif
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       pick = '0;
            1:       pick = N'($urandom_range(0, 15));
            2:       pick = '1;
            3:       pick = N'(1) << $urandom_range(0, N - 1);
            default: pick = N'($urandom);
        endcase
    endfunction

    // Single compare process: scoreboard, stall hold and reset values.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_p", p, 0);
            check("reset_out_tag", out_tag, 0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_p", p, prev_p);
                check("stall_hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_p.size() == 0) begin
                    check("output_with_op_pending", exp_p.size(), 1);
                end else begin
                    check("p", p, exp_p.pop_front());
                    check("out_tag", out_tag, exp_tag.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_p.push_back(model_p(a, b));
                exp_tag.push_back(in_tag);
                accepted++;
            end
            stall_prev = out_valid && !out_ready;
            prev_p     = p;
            prev_tag   = out_tag;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_p.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", exp_p.size(), 0);
    endtask

    task automatic single(input logic [N-1:0] ta, input logic [N-1:0] tb_op,
                          input logic [TAG_W-1:0] tt, input longint unsigned req,
                          input string name);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_op;
        in_tag   = tt;
        @(negedge clk);
        check({name, "_accept"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_p"}, p, req);
        check({name, "_tag"}, out_tag, tt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        in_tag    = '0;

        check("model_ff_x_3", model_p(64'h00FF, 64'h0003), 765);
        check("model_zero_a", model_p(64'h0000, 64'h1234), 0);
        check("model_f_x_f", model_p(64'h000F, 64'h000F), 225);
`ifdef LOBA_LL_TERM_EN
        check("model_ffff_sq", model_p(64'hFFFF, 64'hFFFF), 64'hFE010000);
`else
        check("model_ffff_sq", model_p(64'hFFFF, 64'hFFFF), 64'hFD200000);
`endif

        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 16'h0005;
        b        = 16'h0007;
        in_tag   = 4'h9;
        rst_n    = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        wait_idle();

        single(16'h00FF, 16'h0003, 4'h1, 765, "ff_x_3");
`ifdef LOBA_LL_TERM_EN
        single(16'hFFFF, 16'hFFFF, 4'h2, 64'hFE010000, "ffff_sq");
`else
        single(16'hFFFF, 16'hFFFF, 4'h2, 64'hFD200000, "ffff_sq");
`endif
        single(16'h0000, 16'h1234, 4'h3, 0, "zero_a");
        single(16'h1234, 16'h0000, 4'h4, 0, "zero_b");
        single(16'h000F, 16'h000F, 4'h5, 225, "f_x_f");
        wait_idle();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b1;
                    in_tag   = TAG_W'(i);
                    a        = pick();
                    b        = pick();
                    @(negedge clk);
                    check("b2b_in_ready", in_ready, 1);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 8; i++) begin
                    check("b2b_out_valid", out_valid, 1);
                    check("b2b_out_tag", out_tag, i);
                    @(negedge clk);
                end
                check("b2b_run_end", out_valid, 0);
            end
        join
        wait_idle();

        @(posedge clk);
        #1;
        acc0      = accepted;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            a      = pick();
            b      = pick();
            in_tag = TAG_W'($urandom);
            @(negedge clk);
        end
        #1;
        check("stall_accepted", accepted - acc0, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        wait_idle();

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a        = pick();
            b        = pick();
            in_tag   = TAG_W'(10 + i);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_p.delete();
        exp_tag.delete();
        @(negedge clk);
        check("reset_flush_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_after_reset", out_valid, 0);
        end

        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a         = pick();
            b         = pick();
            in_tag    = TAG_W'($urandom);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loba_pipe_mult.md
LOBA_PIPE_MULT -- requirements
Module: loba_pipe_mult

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width in bits (N >= 2*W).
REQ-002 SHALL have parameter W, default 4, meaning leading-one segment width in bits (W >= 2).
REQ-003 SHALL have parameter TAG_W, default 4, meaning sideband tag width carried alongside each operation.
REQ-004 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operand pair valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have ports a and b, input, N each, unsigned operands.
REQ-009 SHALL have port in_tag, input, TAG_W, opaque tag.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port p, output, 2*N, approximate product.
REQ-013 SHALL have port out_tag, output, TAG_W, tag of the result.

Function
REQ-014 SHALL split each operand X as follows: if X < 2^W then Xh=X, kh=W-1, Xl=0, kl=W-1; otherwise kh = index of the leading one and Xh = X[kh:kh-W+1].
REQ-015 SHALL continue the split from REQ-014 by forming R = X with bits [kh:kh-W+1] cleared, then applying the same rule to R to produce Xl and kl.
REQ-016 SHALL compute p = (Ah*Bh << (kah+kbh-2(W-1))) + (Ah*Bl << (kah+kbl-2(W-1))) + (Al*Bh << (kal+kbh-2(W-1))), in 2*N bits without overflow or truncation.
REQ-017 SHALL use a three-stage pipeline: S1 split and register, S2 three shifted partial products, S3 sum into the output register.
REQ-018 SHALL give a latency of exactly 3 cycles from the in_valid&&in_ready edge to out_valid when out_ready is held high.
REQ-019 SHALL accept one operation per cycle at full throughput, with no bubbles while out_ready=1.
REQ-020 SHALL treat a transfer as occurring only on a cycle where valid&&ready is high, on each side.
REQ-021 SHALL stall, when out_valid=1 and out_ready=0: the output register holds p/out_tag stable, and upstream stages advance only into empty stages.
REQ-022 SHALL drive in_ready = !S1_full || S1 advances this cycle, and it SHALL be combinational, with no dependency on in_valid.
REQ-023 SHALL drop no operations and duplicate none under arbitrary valid/ready patterns; results SHALL emerge in issue order with matching tags.
REQ-024 SHALL produce p=0 when either operand is 0.

Reset
REQ-025 SHALL, while rst_n=0, force all stage-valid flags and out_valid to 0, p=0, out_tag=0; in_ready SHALL be 1 after reset.
REQ-026 SHALL, on reset assertion mid-operation, discard in-flight operations with no output.
REQ-027 SHALL accept input on the first clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro LOBA_LL_TERM_EN is defined, add a fourth term (Al*Bl << (kal+kbl-2(W-1))) in S2/S3.
REQ-029 SHALL, without LOBA_LL_TERM_EN, compute exactly the three-term sum of REQ-016, with no fourth multiplier instantiated.
REQ-030 SHALL have latency and handshake identical in both configurations.

Structure
REQ-031 SHALL place the shift-bias function 2(W-1), the leading-one index width $clog2(N), and the split-result struct type (xh, kh, xl, kl) in shared package loba_pkg.
REQ-032 SHALL implement the split as one combinational sub-module, loba_split_p (parameters N, W), instantiated twice in S1.

Verification
REQ-033 SHALL verify (N=16,W=4) a=0x00FF, b=0x0003, out_ready=1 -> p=765 (0x2FD) after 3 cycles.
REQ-034 SHALL verify a=0xFFFF, b=0xFFFF -> p=0xFD200000 without the macro, and p=0xFE010000 with LOBA_LL_TERM_EN.
REQ-035 SHALL verify a=0, b=0x1234 -> p=0; and a=0x000F, b=0x000F -> p=225.
REQ-036 SHALL verify 8 back-to-back ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order.
REQ-037 SHALL verify out_ready held 0 for 5 cycles with continuous input -> in_ready drops after 3 accepted ops, p stable, no loss after release.
REQ-038 SHALL verify rst_n pulsed low with 2 ops in flight -> out_valid=0, and no stale result after reset.
